pio_regbus_arbiter: RTL and testbench



---
 rtl/pio_regbus_pkg.sv | 22 ++
 rtl/pio_regbus_arbiter_rr_arbiter.sv | 35 +++
 rtl/pio_regbus_arbiter.sv | 111 +++++++++++
 tb/tb_pio_regbus_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pio_regbus_pkg.sv
// Shared types and constants for the PIO register-bus arbiter.
// Register offsets mirror the ones decoded by the PIO control register file.
package pio_regbus_pkg;

   localparam int unsigned ADDR_W = 10;
   localparam logic [ADDR_W-1:0] MAX_ADDR = 10'h140;

   localparam logic [ADDR_W-1:0] CTRL      = 10'h000;
   localparam logic [ADDR_W-1:0] FDEBUG    = 10'h008;
   localparam logic [ADDR_W-1:0] SM0_INSTR = 10'h0D8;
   localparam logic [ADDR_W-1:0] SM1_INSTR = 10'h0F0;
   localparam logic [ADDR_W-1:0] SM2_INSTR = 10'h108;
   localparam logic [ADDR_W-1:0] SM3_INSTR = 10'h120;
   localparam logic [ADDR_W-1:0] IRQ1_INTS = 10'h140;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StResp
   } state_e;

endpackage

// File: rtl/pio_regbus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr,
// searched cyclically, returned as one-hot grant plus binary index.
module rr_arbiter
   import pio_regbus_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   always_comb begin : pick
      int unsigned j;
      logic [IDX_W-1:0] k;
      j   = 0;
      k   = '0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         j = (32'(ptr) + i) % NUM_REQ;
         k = IDX_W'(j);
         if (!any && valid[k]) begin
            any    = 1'b1;
            gnt[k] = 1'b1;
            idx    = k;
         end
      end
   end

endmodule

// File: rtl/pio_regbus_arbiter.sv
// Round-robin arbiter sharing the PIO register file port between NUM_REQ
// requesters; one transaction per IDLE -> ACCESS -> RESP pass.
module pio_regbus_arbiter #(
   parameter int unsigned       NUM_REQ  = 2,
   parameter int unsigned       ADDR_W   = pio_regbus_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] MAX_ADDR = pio_regbus_pkg::MAX_ADDR
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ-1:0]      req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*32-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]      rsp_valid,
   output logic [31:0]             rsp_rdata,
   output logic                    rsp_err,
   output logic                    rf_write_en,
   output logic [ADDR_W-1:0]       rf_write_addr,
   output logic [31:0]             rf_data_in,
   output logic [ADDR_W-1:0]       rf_read_addr,
   input  logic [31:0]             rf_data_out
);
   import pio_regbus_pkg::*;

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e             state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   idx_q;
   logic               write_q;
   logic               legal_q;

   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               any;
   logic [ADDR_W-1:0]  sel_addr;
   logic [31:0]        sel_wdata;
   logic               sel_write;
   logic               sel_legal;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .gnt   (gnt),
      .idx   (gnt_idx),
      .any   (any)
   );

   // Ready is forced low while rst is held so all outputs read zero in reset.
   assign req_ready = (state == StIdle && !rst) ? gnt : '0;
   assign sel_addr  = req_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];
   assign sel_wdata = req_wdata[32'(gnt_idx)*32 +: 32];
   assign sel_write = req_write[gnt_idx];
   assign sel_legal = (sel_addr[1:0] == 2'b00) && (sel_addr <= MAX_ADDR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= StIdle;
         rr_ptr        <= '0;
         idx_q         <= '0;
         write_q       <= 1'b0;
         legal_q       <= 1'b0;
         rsp_valid     <= '0;
         rsp_rdata     <= '0;
         rsp_err       <= 1'b0;
         rf_write_en   <= 1'b0;
         rf_write_addr <= '0;
         rf_data_in    <= '0;
         rf_read_addr  <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (any) begin
                  idx_q   <= gnt_idx;
                  write_q <= sel_write;
                  legal_q <= sel_legal;
                  // Strobe is registered here so it is high for the ACCESS cycle only.
                  if (sel_legal && sel_write) begin
                     rf_write_en   <= 1'b1;
                     rf_write_addr <= sel_addr;
                     rf_data_in    <= sel_wdata;
                  end else if (sel_legal) begin
                     rf_read_addr  <= sel_addr;
                  end
                  state <= StAccess;
               end
            end
            StAccess: begin
               rf_write_en <= 1'b0;
               rsp_valid   <= NUM_REQ'(1) << idx_q;
               rsp_rdata   <= (legal_q && !write_q) ? rf_data_out : '0;
               rsp_err     <= !legal_q;
               state       <= StResp;
            end
            StResp: begin
               rsp_valid <= '0;
               rsp_rdata <= '0;
               rsp_err   <= 1'b0;
               rr_ptr    <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
               state     <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_pio_regbus_arbiter.sv
// Directed bench for pio_regbus_arbiter with a small register-file model
// that updates on rf_write_en and reads combinationally.
module tb_pio_regbus_arbiter;

   localparam int unsigned NUM_REQ = 2;
   localparam int unsigned ADDR_W  = 10;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*32-1:0]     req_wdata;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [31:0]               rsp_rdata;
   logic                      rsp_err;
   logic                      rf_write_en;
   logic [ADDR_W-1:0]         rf_write_addr;
   logic [31:0]               rf_data_in;
   logic [ADDR_W-1:0]         rf_read_addr;
   logic [31:0]               rf_data_out;

   logic [31:0] mem [0:255];
   logic        pre_we;
   logic [7:0]  pre_a;
   logic [31:0] pre_d;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pio_regbus_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .ADDR_W   (ADDR_W),
      .MAX_ADDR (10'h140)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_write     (req_write),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_rdata     (rsp_rdata),
      .rsp_err       (rsp_err),
      .rf_write_en   (rf_write_en),
      .rf_write_addr (rf_write_addr),
      .rf_data_in    (rf_data_in),
      .rf_read_addr  (rf_read_addr),
      .rf_data_out   (rf_data_out)
   );

   assign rf_data_out = mem[rf_read_addr[9:2]];

   always @(posedge clk) begin
      if (pre_we) mem[pre_a] <= pre_d;
      else if (rf_write_en) mem[rf_write_addr[9:2]] <= rf_data_in;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input int r, input bit w, input logic [9:0] a,
                            input logic [31:0] d);
      req_valid[r]           = 1'b1;
      req_write[r]           = w;
      req_addr[r*10 +: 10]   = a;
      req_wdata[r*32 +: 32]  = d;
   endtask

   task automatic preload(input logic [9:0] a, input logic [31:0] d);
      @(negedge clk);
      pre_we = 1'b1;
      pre_a  = a[9:2];
      pre_d  = d;
   endtask

   // One full transaction from requester r, checked in each of its three cycles.
   task automatic txn(input int r, input bit w, input logic [9:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input bit exp_err);
      bit exp_we;
      exp_we = w && !exp_err;
      @(negedge clk);
      drive_req(r, w, a, d);
      #1;
      check("idle_ready", 32'(req_ready), 32'(1) << r);
      @(negedge clk);
      req_valid = '0;
      #1;
      check("acc_write_en", 32'(rf_write_en), 32'(exp_we));
      check("acc_ready_low", 32'(req_ready), 32'd0);
      check("acc_rsp_low", 32'(rsp_valid), 32'd0);
      if (exp_we) begin
         check("acc_write_addr", 32'(rf_write_addr), 32'(a));
         check("acc_data_in", rf_data_in, d);
      end
      if (!w && !exp_err) check("acc_read_addr", 32'(rf_read_addr), 32'(a));
      @(negedge clk);
      #1;
      check("rsp_valid", 32'(rsp_valid), 32'(1) << r);
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
      check("rsp_write_en", 32'(rf_write_en), 32'd0);
   endtask

   initial begin
      int g;
      int nr;
      rst       = 1'b1;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      pre_we    = 1'b0;
      pre_a     = '0;
      pre_d     = '0;

      preload(10'h008, 32'h1234_5678);
      preload(10'h0C8, 32'h0001_0000);
      preload(10'h0DC, 32'h0000_0000);
      preload(10'h010, 32'h0000_0000);
      @(negedge clk);
      pre_we    = 1'b0;
      req_valid = 2'b11;
      #1;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_write_en", 32'(rf_write_en), 32'd0);
      check("rst_read_addr", 32'(rf_read_addr), 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;

      txn(0, 1'b1, 10'h000, 32'h0000_000F, 32'h0, 1'b0);
      txn(1, 1'b0, 10'h0C8, 32'h0, 32'h0001_0000, 1'b0);

      // Both requesters held valid: grants must alternate 0,1,0,1.
      @(negedge clk);
      drive_req(0, 1'b0, 10'h000, 32'h0);
      drive_req(1, 1'b0, 10'h008, 32'h0);
      g  = 0;
      nr = 0;
      for (int c = 0; c < 16; c++) begin
         #1;
         check("rr_onehot0", 32'($onehot0(req_ready)), 32'd1);
         if (req_ready != '0) begin
            check("rr_grant", 32'(req_ready), 32'(1) << (g % 2));
            g++;
         end
         if (rsp_valid != '0) begin
            check("rr_rsp_owner", 32'(rsp_valid), 32'(1) << (nr % 2));
            check("rr_rsp_rdata", rsp_rdata, (nr % 2 == 1) ? 32'h1234_5678 : 32'h0000_000F);
            nr++;
         end
         @(negedge clk);
         if (g == 4) req_valid = '0;
      end
      check("rr_grant_count", 32'(g), 32'd4);
      check("rr_rsp_count", 32'(nr), 32'd4);

      txn(0, 1'b1, 10'h0D9, 32'h0000_0001, 32'h0, 1'b1);
      txn(0, 1'b1, 10'h144, 32'h0000_0002, 32'h0, 1'b1);

      // Abort a write mid-ACCESS; rr_ptr is 1 here, so reset must bring it back to 0.
      @(negedge clk);
      drive_req(1, 1'b1, 10'h010, 32'hDEAD_BEEF);
      #1;
      check("abort_ready", 32'(req_ready), 32'b10);
      @(negedge clk);
      req_valid = '0;
      #1;
      check("abort_acc_we", 32'(rf_write_en), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_we_drop", 32'(rf_write_en), 32'd0);
      check("abort_rsp_low", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      check("abort_mem_untouched", mem[4], 32'h0);
      @(negedge clk);
      drive_req(0, 1'b0, 10'h008, 32'h0);
      drive_req(1, 1'b0, 10'h000, 32'h0);
      #1;
      check("post_rst_grant", 32'(req_ready), 32'b01);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #1;
      check("post_rst_rsp", 32'(rsp_valid), 32'b01);
      check("post_rst_rdata", rsp_rdata, 32'h1234_5678);

      txn(1, 1'b1, 10'h0DC, 32'hA5A5_A5A5, 32'h0, 1'b0);
      txn(0, 1'b0, 10'h0DC, 32'h0, 32'hA5A5_A5A5, 1'b0);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
